// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word request into one or two byte-enabled
// word accesses to a synchronous RAM and returns aligned, extended load data.
module load_store_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wd,
  input  logic [1:0]        i_req_mask_type,
  input  logic              i_req_ext_type,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rd,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wd,
  input  logic [31:0]       i_mem_rd
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    SECOND = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, next_state;

  logic              req_we;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wd;
  logic [1:0]        req_mask;
  logic              req_ext;
  logic [31:0]       lo, hi;

  logic              src_we;
  logic [ADDR_W+1:0] src_addr;
  logic [31:0]       src_wd;
  logic [1:0]        src_mask;
  logic [1:0]        off;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic              split;
  logic [ADDR_W-1:0] w0, w1;

  logic [ADDR_W-1:0] mem_addr_n;
  logic              mem_re_n, mem_we_n;
  logic [3:0]        mem_be_n;
  logic [31:0]       mem_wd_n;
  logic [31:0]       lo_n, hi_n, rsp_rd_n;

  logic unused_addr_bits;
  assign unused_addr_bits = ^i_req_addr[31:ADDR_W+2];

  function automatic logic [7:0] lane_be8(input logic [1:0] mask, input logic [1:0] ofs);
    logic [7:0] base;
    case (mask)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << ofs;
  endfunction

  function automatic logic [31:0] load_extend(input logic [63:0] pair, input logic [1:0] ofs,
                                              input logic [1:0] mask, input logic ext);
    logic [63:0] sh;
    sh = pair >> {ofs, 3'b000};
    case (mask)
      2'b00:   return ext ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return ext ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh[31:0];
    endcase
  endfunction

  // In IDLE the lane math looks at the incoming request so FIRST outputs can be registered.
  always_comb begin
    if (state == IDLE) begin
      src_we   = i_req_we;
      src_addr = i_req_addr[ADDR_W+1:0];
      src_wd   = i_req_wd;
      src_mask = i_req_mask_type;
    end else begin
      src_we   = req_we;
      src_addr = req_addr;
      src_wd   = req_wd;
      src_mask = req_mask;
    end
    off   = src_addr[1:0];
    be8   = lane_be8(src_mask, off);
    wd64  = {32'h00000000, src_wd} << {off, 3'b000};
    split = |be8[7:4];
    w0    = src_addr[ADDR_W+1:2];
    w1    = w0 + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_req_valid) next_state = FIRST;
        else             next_state = IDLE;
      end
      FIRST: begin
        if (src_mask == 2'b11) next_state = DONE;
        else if (split)        next_state = SECOND;
        else if (src_we)       next_state = DONE;
        else                   next_state = WAIT;
      end
      SECOND: begin
        if (src_we) next_state = DONE;
        else        next_state = WAIT;
      end
      WAIT:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered memory port, load captures and response data.
  always_comb begin
    mem_addr_n = '0;
    mem_re_n   = 1'b0;
    mem_we_n   = 1'b0;
    mem_be_n   = 4'b0000;
    mem_wd_n   = 32'h00000000;
    if (next_state == FIRST) begin
      if (src_mask != 2'b11) begin
        mem_addr_n = w0;
        mem_be_n   = be8[3:0];
        mem_wd_n   = wd64[31:0];
        mem_we_n   = src_we;
        mem_re_n   = !src_we;
      end else begin
        mem_addr_n = '0;
      end
    end else if (next_state == SECOND) begin
      mem_addr_n = w1;
      mem_be_n   = be8[7:4];
      mem_wd_n   = wd64[63:32];
      mem_we_n   = src_we;
      mem_re_n   = !src_we;
    end else begin
      mem_addr_n = '0;
    end

    lo_n = lo;
    hi_n = hi;
    if (state == SECOND && !req_we) begin
      lo_n = i_mem_rd;
    end else if (state == WAIT) begin
      if (split) hi_n = i_mem_rd;
      else       lo_n = i_mem_rd;
    end else begin
      lo_n = lo;
    end

    if (!src_we && src_mask != 2'b11) rsp_rd_n = load_extend({hi_n, lo_n}, off, src_mask, req_ext);
    else                              rsp_rd_n = 32'h00000000;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_we   <= 1'b0;
      req_addr <= '0;
      req_wd   <= 32'h00000000;
      req_mask <= 2'b00;
      req_ext  <= 1'b0;
      lo       <= 32'h00000000;
      hi       <= 32'h00000000;
    end else begin
      if (state == IDLE && i_req_valid) begin
        req_we   <= i_req_we;
        req_addr <= i_req_addr[ADDR_W+1:0];
        req_wd   <= i_req_wd;
        req_mask <= i_req_mask_type;
        req_ext  <= i_req_ext_type;
      end
      lo <= lo_n;
      hi <= hi_n;
    end
  end

  // Response data and error only change on entry to DONE, so they hold between completions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_req_ready <= 1'b1;
      o_busy      <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rd    <= 32'h00000000;
      o_rsp_err   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= 4'b0000;
      o_mem_wd    <= 32'h00000000;
    end else begin
      o_req_ready <= (next_state == IDLE);
      o_busy      <= (next_state != IDLE);
      o_rsp_valid <= (next_state == DONE);
      if (next_state == DONE) begin
        o_rsp_rd  <= rsp_rd_n;
        o_rsp_err <= (src_mask == 2'b11);
      end
      o_mem_addr <= mem_addr_n;
      o_mem_re   <= mem_re_n;
      o_mem_we   <= mem_we_n;
      o_mem_be   <= mem_be_n;
      o_mem_wd   <= mem_wd_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-addressed reference memory model,
// word RAM behind the DUT, directed cases and a mid-operation reset.
module tb_load_store_unit;
  localparam int ADDR_W = 6;
  localparam int NB     = 4 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req_valid, i_req_we, i_req_ext_type;
  logic [31:0]       i_req_addr, i_req_wd;
  logic [1:0]        i_req_mask_type;
  logic              o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic [31:0]       o_rsp_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_re, o_mem_we;
  logic [3:0]        o_mem_be;
  logic [31:0]       o_mem_wd, i_mem_rd;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wd(i_req_wd),
    .i_req_mask_type(i_req_mask_type), .i_req_ext_type(i_req_ext_type),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rd(o_rsp_rd), .o_rsp_err(o_rsp_err),
    .o_busy(o_busy), .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re),
    .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_wd(o_mem_wd),
    .i_mem_rd(i_mem_rd)
  );

  // Word RAM with byte enables, read data one cycle after the read strobe.
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic [31:0] rd_q = 32'h0;
  always @(posedge clk) begin
    if (o_mem_we)
      for (int l = 0; l < 4; l++)
        if (o_mem_be[l]) ram[o_mem_addr][8*l +: 8] <= o_mem_wd[8*l +: 8];
    if (o_mem_re) rd_q <= ram[o_mem_addr];
  end
  assign i_mem_rd = rd_q;

  logic [7:0]  ref_mem [0:NB-1];
  int          total = 0;
  int          bad = 0;
  logic [31:0] prev_rd;
  logic        prev_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_extend(input logic [31:0] v, input int n, input logic ext);
    logic [31:0] m;
    if (n == 4) return v;
    m = (32'h1 << (8 * n)) - 32'h1;
    if (ext || !v[8*n-1]) return v & m;
    return v | ~m;
  endfunction

  task automatic drive_random_fields();
    logic [31:0] r;
    r = $urandom;
    i_req_we = r[0]; i_req_ext_type = r[1]; i_req_mask_type = r[3:2];
    i_req_addr = $urandom; i_req_wd = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] mask, input logic ext, output logic [31:0] rd_obs);
    int          n, o, ba, w, idx, exp_nacc, nacc, lat, exp_lat;
    logic        err;
    logic [5:0]  exp_addr [4];
    logic [5:0]  acc_addr [4];
    logic [3:0]  exp_be [4];
    logic [3:0]  acc_be [4];
    logic [31:0] exp_wd [4];
    logic [31:0] acc_wd [4];
    logic        acc_we [4];
    logic [31:0] v, exp_rd;
    err = (mask == 2'b11);
    n = (mask == 2'b00) ? 1 : (mask == 2'b01) ? 2 : 4;
    o = int'(addr[1:0]);
    exp_nacc = 0;
    v = 32'h0;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        ba = (int'(addr[7:0]) + k) % NB;
        w  = ba / 4;
        if (exp_nacc == 0 || exp_addr[exp_nacc-1] != w[5:0]) begin
          exp_addr[exp_nacc] = w[5:0];
          exp_be[exp_nacc] = 4'b0000;
          exp_nacc++;
        end
        exp_be[exp_nacc-1][ba % 4] = 1'b1;
        v[8*k +: 8] = ref_mem[ba];
        if (we) ref_mem[ba] = wd[8*k +: 8];
      end
    end
    for (int j = 0; j < exp_nacc; j++) begin
      exp_wd[j] = 32'h0;
      for (int l = 0; l < 4; l++) begin
        idx = 4 * j + l - o;
        if (idx >= 0 && idx < 4) exp_wd[j][8*l +: 8] = wd[8*idx +: 8];
      end
    end
    exp_lat = err ? 2 : ((we ? 2 : 3) + ((exp_nacc == 2) ? 1 : 0));
    exp_rd  = (err || we) ? 32'h0 : ref_extend(v, n, ext);

    @(negedge clk);
    check_eq("idle_ready", {31'd0, o_req_ready}, 32'd1);
    check_eq("idle_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rsp_pulse", {31'd0, o_rsp_valid}, 32'd0);
    check_eq("hold_rd", o_rsp_rd, prev_rd);
    check_eq("hold_err", {31'd0, o_rsp_err}, {31'd0, prev_err});
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wd = wd;
    i_req_mask_type = mask; i_req_ext_type = ext;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    drive_random_fields();
    nacc = 0; lat = 0; rd_obs = 32'h0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      check_eq("busy", {31'd0, o_busy}, 32'd1);
      check_eq("ready_low", {31'd0, o_req_ready}, 32'd0);
      check_eq("we_re_excl", {31'd0, o_mem_we & o_mem_re}, 32'd0);
      if (o_mem_we || o_mem_re) begin
        if (nacc < 4) begin
          acc_addr[nacc] = o_mem_addr; acc_be[nacc] = o_mem_be;
          acc_wd[nacc] = o_mem_wd; acc_we[nacc] = o_mem_we;
        end
        nacc++;
      end
      if (o_rsp_valid) begin
        lat = c;
        rd_obs = o_rsp_rd;
        check_eq("rsp_err", {31'd0, o_rsp_err}, {31'd0, err});
      end
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("n_access", 32'(nacc), 32'(exp_nacc));
    for (int j = 0; j < exp_nacc && j < nacc && j < 4; j++) begin
      check_eq("acc_addr", {26'd0, acc_addr[j]}, {26'd0, exp_addr[j]});
      check_eq("acc_be", {28'd0, acc_be[j]}, {28'd0, exp_be[j]});
      check_eq("acc_dir", {31'd0, acc_we[j]}, {31'd0, we});
      if (we) check_eq("acc_wd", acc_wd[j], exp_wd[j]);
    end
    check_eq("rsp_rd", rd_obs, exp_rd);
    prev_rd = exp_rd;
    prev_err = err;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_we"}, {31'd0, o_mem_we}, 32'd0);
    check_eq({tag, "_re"}, {31'd0, o_mem_re}, 32'd0);
    check_eq({tag, "_rsp"}, {31'd0, o_rsp_valid}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, o_req_ready}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, r;
    rst_n = 1'b0;
    i_req_valid = 1'b0;
    drive_random_fields();
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    check_eq("rst_rd", o_rsp_rd, 32'h0);
    check_eq("rst_err", {31'd0, o_rsp_err}, 32'd0);
    check_eq("rst_addr", {26'd0, o_mem_addr}, 32'd0);
    check_eq("rst_be", {28'd0, o_mem_be}, 32'd0);
    check_eq("rst_wd", o_mem_wd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_rel");
    prev_rd = 32'h0;
    prev_err = 1'b0;

    for (int w = 0; w < (1 << ADDR_W); w++) do_req(1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, rd);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd);
    check_eq("tp_lw", rd, 32'hDEADBEEF);
    do_req(1'b1, 32'h0, 32'h80FF1234, 2'b10, 1'b0, rd);
    do_req(1'b0, 32'h3, 32'h0, 2'b00, 1'b0, rd);
    check_eq("tp_lb", rd, 32'hFFFFFF80);
    do_req(1'b0, 32'h3, 32'h0, 2'b00, 1'b1, rd);
    check_eq("tp_lbu", rd, 32'h00000080);
    do_req(1'b0, 32'h1, 32'h0, 2'b01, 1'b1, rd);
    check_eq("tp_lhu", rd, 32'h0000FF12);
    do_req(1'b1, 32'h4, 32'hDDCCBBAA, 2'b10, 1'b0, rd);
    do_req(1'b1, 32'h8, 32'h44332211, 2'b10, 1'b0, rd);
    do_req(1'b0, 32'h6, 32'h0, 2'b10, 1'b0, rd);
    check_eq("tp_split_lw", rd, 32'h2211DDCC);
    do_req(1'b1, 32'h7, 32'h0000BEEF, 2'b01, 1'b0, rd);
    do_req(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd);
    check_eq("tp_sh_w1", rd, 32'hEFCCBBAA);
    do_req(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, rd);
    check_eq("tp_sh_w2", rd, 32'h443322BE);
    do_req(1'b0, 32'hFE, 32'h0, 2'b10, 1'b0, rd);
    do_req(1'b0, 32'h20, 32'h0, 2'b11, 1'b0, rd);
    do_req(1'b1, 32'h23, 32'h12345678, 2'b11, 1'b1, rd);

    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      do_req(r[0], $urandom, $urandom, r[2:1], r[3], rd);
    end

    // Reset during the second write of a split halfword store.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h7;
    i_req_wd = 32'h0000A55A; i_req_mask_type = 2'b01; i_req_ext_type = 1'b0;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_second_we", {31'd0, o_mem_we}, 32'd1);
    check_eq("mid_second_addr", {26'd0, o_mem_addr}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_rst");
    ref_mem[7] = 8'h5A;
    repeat (2) begin
      @(negedge clk);
      check_quiet("in_rst");
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("rel_rst");
    prev_rd = 32'h0;
    prev_err = 1'b0;
    do_req(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd);
    do_req(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, rd);
    do_req(1'b0, 32'h7, 32'h0, 2'b00, 1'b1, rd);
    check_eq("rst_partial_byte", rd, 32'h0000005A);

    @(negedge clk);
    for (int w = 0; w < (1 << ADDR_W); w++)
      check_eq("ram_final", ram[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
